svutest_req_payload_buffer: RTL
===============================

# svutest_req_payload_buffer

Elastic FIFO stage between a fire-and-forget request source (req/payload, no backpressure) and a request-payload-response target that acknowledges each request with `rsp`. Absorbs bursts from a test sequence, presents one request at a time downstream, and holds it stable until acknowledged. Reports occupancy and sticky error flags (overflow, spurious response, response timeout) for the test control logic.

## Interface
- `T_payload`, default `logic`: payload type; the width W = `$bits(T_payload)`.
- `DEPTH`, default 4: number of entries; any integer ≥ 2.
- `TIMEOUT_CYCLES`, default 0: maximum number of cycles a request may wait for `rsp`; 0 disables the check.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_req`  in  1  upstream request strobe; one push per cycle it is high.
- `in_payload`  in  W  payload; sampled when `in_req`=1.
- `out_req`  out  1  downstream request valid; high while the FIFO is non-empty.
- `out_payload`  out  W  head-entry payload; '0 when `out_req`=0.
- `out_rsp`  in  1  downstream acknowledge; pops the head when `out_req`=1.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full` / `empty`  out  1  `count`==DEPTH / `count`==0.
- `overflow`  out  1  sticky: a push was dropped.
- `spurious_rsp`  out  1  sticky: `out_rsp`=1 while `out_req`=0.
- `timeout`  out  1  sticky: the head request waited longer than TIMEOUT_CYCLES.

## Operation
- Circular storage with write and read pointers. Each pointer wraps from DEPTH-1 to 0; DEPTH does not need to be a power of two. Occupancy is tracked by an explicit counter, not by pointer difference.
- Push: `in_req`=1 and (not full or pop in the same cycle). The payload is written at the write pointer and the write pointer advances.
- Pop: `out_req`=1 and `out_rsp`=1. The read pointer advances.
- Simultaneous push and pop: both happen and `count` is unchanged. This applies even when full: the push is accepted because the pop frees a slot in the same cycle.
- Push while full with no pop: the payload is dropped, `overflow` is set, and the stored contents are unchanged.
- `out_rsp`=1 while `out_req`=0: `spurious_rsp` is set and the FIFO state is unchanged.
- Wait counter:
  - Clears on a pop and while empty.
  - Increments each cycle that `out_req`=1 and `out_rsp`=0, and saturates.
  - When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, `timeout` is set. The request remains presented.
- All sticky flags clear only on `rst`.
- Downstream contract: `out_payload` is stable while `out_req`=1 and no pop occurs.

## Timing
- Reset values: `out_req`=0, `out_payload`='0, `count`=0, `empty`=1, `full`=0, and all sticky flags 0. Pointers and the wait counter reset to 0. Storage contents are not reset.
- `rst` mid-operation discards all entries. The cycle after reset, outputs hold the reset values regardless of `in_req` or `out_rsp` during the reset cycle.
- Latency: a push into an empty FIFO at edge N makes `out_req`=1 with that payload after edge N, i.e. 1 cycle later. There is no combinational path from `in_*` to `out_*`.
- Back-to-back: when a pop occurs at edge N and another entry remains, `out_req` stays 1 and `out_payload` shows the next entry after edge N. There is no bubble.
- Throughput: one push and one pop per cycle are sustained.
- `count`, `full`, `empty` and the flags are registered or derived from registers, and update after the edge that caused the change.
- The timeout flag sets at the edge where the wait counter becomes TIMEOUT_CYCLES, i.e. after the request has been waiting TIMEOUT_CYCLES cycles.

## Test plan
- Reset, then idle 5 cycles -> `out_req`=0, `count`=0, `empty`=1, all flags 0.
- Push 0x11 at cycle 0; hold `out_rsp`=0 for 3 cycles, then pulse it -> `out_req`=1 with 0x11 from cycle 1 through the rsp cycle. After the pop: `out_req`=0, `count`=0.
- DEPTH=4: push 0xA0..0xA3 back-to-back, then push 0xA4 with no rsp -> `full`=1, `overflow`=1. Then hold `out_rsp`=1 -> payloads 0xA0, 0xA1, 0xA2, 0xA3 appear on consecutive cycles and 0xA4 never appears.
- While full, push 0xB0 in the same cycle as `out_rsp`=1 -> `count` stays 4, `overflow` stays 0, and 0xB0 emerges last after pointer wrap.
- Pulse `out_rsp` with the FIFO empty -> `spurious_rsp`=1. `count` stays 0, and the flag persists until `rst`.
- TIMEOUT_CYCLES=8: push one entry and never respond -> `timeout` rises 8 cycles after `out_req` rises, and `out_req` and `out_payload` are held. Assert `rst` -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/svutest_req_payload_buffer.sv
// ============================================================================
// Module   : svutest_req_payload_buffer
// Brief    : Elastic request FIFO with occupancy and sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module svutest_req_payload_buffer #(
    parameter type T_payload      = logic,
    parameter int  DEPTH          = 4,
    parameter int  TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_req,
    input  T_payload                   in_payload,
    output logic                       out_req,
    output T_payload                   out_payload,
    input  logic                       out_rsp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       spurious_rsp,
    output logic                       timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [WW-1:0] c_wait_max = '1;
    localparam logic [WW-1:0] c_timeout  = WW'(TIMEOUT_CYCLES);

    T_payload      r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_overflow;
    logic          r_spurious;
    logic          r_timeout;

    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [WW-1:0] w_wait_next;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_rsp;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = in_req && (!w_full || w_pop);

    always_comb begin
        w_wait_next = r_wait;
        if (w_empty || w_pop) begin
            w_wait_next = '0;
        end else if (r_wait != c_wait_max) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait     <= '0;
            r_overflow <= 1'b0;
            r_spurious <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_wait <= w_wait_next;
            if (in_req && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (out_rsp && w_empty) begin
                r_spurious <= 1'b1;
            end
            if ((TIMEOUT_CYCLES > 0) && (w_wait_next >= c_timeout)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign out_req      = !w_empty;
    assign out_payload  = w_empty ? T_payload'('0) : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow     = r_overflow;
    assign spurious_rsp = r_spurious;
    assign timeout      = r_timeout;

endmodule

`default_nettype wire
